// File: rtl/encoder_seq_pkg.sv
// Shared state encoding and geometry constants for the encoder step sequencer.
package encoder_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_SWAP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } seq_state_e;

  localparam int ADDR_W_DEF = 6;
  localparam int LANE_W_DEF = 25;
  localparam int LINES      = 64;
  localparam int ROUND_W    = 5;

endpackage

// File: rtl/encoder_step_sequencer_stage_watchdog.sv
// stage_watchdog: RUN-cycle counter for the active engine; term_o flags a hung stage.
module stage_watchdog
  import encoder_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Parks at the terminal value so the flag cannot wrap away before the FSM acts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/encoder_step_sequencer.sv
// Step sequencer: runs the stage engines in order for each round over the ping-pong lane memory.
// Optional cycle_count output when SEQ_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a start rising edge
// CLEAR | one-cycle clear pulse to the active engine
// RUN   | active engine enabled, watchdog counting
// SWAP  | flip banks, advance stage/round
// DONE  | result ready in rd_bank, wait for start low
// ERR   | watchdog expired, held until reset
module encoder_step_sequencer
  import encoder_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_ROUNDS  = 24,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LANE_W      = LANE_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  output logic                         busy,
  output logic                         error,
  output logic [ROUND_W-1:0]           round,
  output logic [NUM_STAGES-1:0]        stage_clr,
  output logic [NUM_STAGES-1:0]        stage_en,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_cnt,
  input  logic [NUM_STAGES-1:0]        stage_wr_en,
  input  logic [NUM_STAGES*LANE_W-1:0] stage_wr_val,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  output logic                         mem_rd_bank,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic                         mem_wr_bank,
  output logic [LANE_W-1:0]            mem_wr_data
`ifdef SEQ_PERF_CNT_EN
  ,output logic [31:0]                 cycle_count
`endif
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [SW-1:0]         LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [ROUND_W-1:0]    LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0_OH  = NUM_STAGES'(1);

  seq_state_e              state_q;
  logic [SW-1:0]           stage_q;
  logic [ROUND_W-1:0]      round_q;
  logic                    rd_bank_q;
  logic                    start_q;
  logic                    done_q, busy_q, error_q;
  logic [NUM_STAGES-1:0]   clr_q, en_q;
  logic                    start_edge;
  logic                    wd_term;

  logic [ADDR_W-1:0] cnt_arr [NUM_STAGES];
  logic [LANE_W-1:0] val_arr [NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
    assign cnt_arr[g] = stage_cnt[g*ADDR_W +: ADDR_W];
    assign val_arr[g] = stage_wr_val[g*LANE_W +: LANE_W];
  end

  assign start_edge = start & ~start_q;

  stage_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_CLEAR),
    .en_i  (state_q == ST_RUN),
    .term_o(wd_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      round_q   <= '0;
      rd_bank_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
      clr_q     <= '0;
      en_q      <= '0;
    end else begin
      start_q <= start;
      clr_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            stage_q   <= '0;
            round_q   <= '0;
            rd_bank_q <= 1'b0;
            busy_q    <= 1'b1;
            clr_q     <= STAGE0_OH;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          en_q    <= STAGE0_OH << stage_q;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Engine completion takes priority over a coincident timeout.
          if (stage_done[stage_q]) begin
            en_q    <= '0;
            state_q <= ST_SWAP;
          end else if (wd_term) begin
            en_q    <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= ST_ERR;
          end
        end
        ST_SWAP: begin
          rd_bank_q <= ~rd_bank_q;
          if (stage_q < LAST_STAGE) begin
            stage_q <= stage_q + 1'b1;
            clr_q   <= STAGE0_OH << (stage_q + 1'b1);
            state_q <= ST_CLEAR;
          end else if (round_q < LAST_ROUND) begin
            stage_q <= '0;
            round_q <= round_q + 1'b1;
            clr_q   <= STAGE0_OH;
            state_q <= ST_CLEAR;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          en_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign busy      = busy_q;
  assign error     = error_q;
  assign round     = round_q;
  assign stage_clr = clr_q;
  assign stage_en  = en_q;

  // Zero-latency routing from the registered stage index; inactive engines never reach memory.
  assign mem_rd_addr = cnt_arr[stage_q];
  assign mem_wr_addr = cnt_arr[stage_q];
  assign mem_wr_data = val_arr[stage_q];
  assign mem_wr_en   = stage_wr_en[stage_q] && (state_q == ST_RUN);
  assign mem_rd_bank = rd_bank_q;
  assign mem_wr_bank = ~rd_bank_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if ((state_q == ST_IDLE) && start_edge) begin
      cyc_q <= '0;
    end else if (busy_q && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_encoder_step_sequencer.sv
// Directed bench: two sequencer instances (long timeout with stub engines, short timeout for the watchdog).
`timescale 1ns/1ps
module tb_encoder_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 2 stages, 2 rounds, default timeout
  logic        rst_a, start_a;
  logic        done_a, busy_a, error_a;
  logic [4:0]  round_a;
  logic [1:0]  clr_a, en_a, sdone_a, wren_a;
  logic [11:0] cnt_a;
  logic [49:0] val_a;
  logic [5:0]  rd_addr_a, wr_addr_a;
  logic        rd_bank_a, wr_en_a, wr_bank_a;
  logic [24:0] wr_data_a;

  // Instance B: 2 stages, 2 rounds, timeout 16, engines never finish
  logic        rst_b, start_b;
  logic        done_b, busy_b, error_b;
  logic [4:0]  round_b;
  logic [1:0]  clr_b, en_b;
  logic [5:0]  rd_addr_b, wr_addr_b;
  logic        rd_bank_b, wr_en_b, wr_bank_b;
  logic [24:0] wr_data_b;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_a, cyc_b;
`endif

  logic        auto_mode;
  logic [1:0]  tb_done;
  logic [11:0] tb_cnt;
  logic [6:0]  eng0, eng1;

  // Stub engines: done on the 64th enabled cycle after a clear.
  always @(posedge clk) begin
    if (clr_a[0]) eng0 <= 7'd0; else if (en_a[0]) eng0 <= eng0 + 7'd1;
    if (clr_a[1]) eng1 <= 7'd0; else if (en_a[1]) eng1 <= eng1 + 7'd1;
  end

  assign sdone_a = auto_mode ? {en_a[1] && (eng1 == 7'd63), en_a[0] && (eng0 == 7'd63)} : tb_done;
  assign cnt_a   = auto_mode ? {eng1[5:0], eng0[5:0]} : tb_cnt;

  encoder_step_sequencer #(
    .NUM_STAGES(2), .NUM_ROUNDS(2), .ADDR_W(6), .LANE_W(25), .TIMEOUT_CYC(1024)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .done(done_a), .busy(busy_a), .error(error_a), .round(round_a),
    .stage_clr(clr_a), .stage_en(en_a), .stage_done(sdone_a),
    .stage_cnt(cnt_a), .stage_wr_en(wren_a), .stage_wr_val(val_a),
    .mem_rd_addr(rd_addr_a), .mem_rd_bank(rd_bank_a), .mem_wr_en(wr_en_a),
    .mem_wr_addr(wr_addr_a), .mem_wr_bank(wr_bank_a), .mem_wr_data(wr_data_a)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cyc_a)
`endif
  );

  encoder_step_sequencer #(
    .NUM_STAGES(2), .NUM_ROUNDS(2), .ADDR_W(6), .LANE_W(25), .TIMEOUT_CYC(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .done(done_b), .busy(busy_b), .error(error_b), .round(round_b),
    .stage_clr(clr_b), .stage_en(en_b), .stage_done(2'b00),
    .stage_cnt(12'd0), .stage_wr_en(2'b00), .stage_wr_val(50'd0),
    .mem_rd_addr(rd_addr_b), .mem_rd_bank(rd_bank_b), .mem_wr_en(wr_en_b),
    .mem_wr_addr(wr_addr_b), .mem_wr_bank(wr_bank_b), .mem_wr_data(wr_data_b)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count(cyc_b)
`endif
  );

  task automatic wait_en_a(input logic [1:0] want, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (en_a === want) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s stage_en=%b required %b", name, en_a, want);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    auto_mode = 1'b1; tb_done = 2'b00; tb_cnt = '0; wren_a = 2'b00; val_a = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done_a, busy_a, error_a} !== 3'b000) begin
      failures++; $display("FAIL reset_flags_a got %b required 000", {done_a, busy_a, error_a});
    end
    checks++;
    if ({clr_a, en_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_clr_en_a got %b required 0000", {clr_a, en_a});
    end
    checks++;
    if (round_a !== 5'd0) begin
      failures++; $display("FAIL reset_round_a got %0d required 0", round_a);
    end
    checks++;
    if ({rd_bank_a, wr_bank_a, wr_en_a} !== 3'b010) begin
      failures++; $display("FAIL reset_banks_a got rd=%b wr=%b wr_en=%b required 0 1 0", rd_bank_a, wr_bank_a, wr_en_a);
    end
    checks++;
    if ({done_b, busy_b, error_b, clr_b, en_b} !== 7'd0) begin
      failures++; $display("FAIL reset_b got %b required 0", {done_b, busy_b, error_b, clr_b, en_b});
    end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({done_a, busy_a, clr_a, en_a} !== 6'd0) begin
      failures++; $display("FAIL idle_after_reset got %b required 0", {done_a, busy_a, clr_a, en_a});
    end
  endtask

  task automatic test_full_run();
    int n;
    bit got;
    auto_mode = 1'b1; wren_a = 2'b00;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b1 || clr_a !== 2'b01) begin
      failures++; $display("FAIL run_first_clear got busy=%b clr=%b required 1 01", busy_a, clr_a);
    end
    n = 0; got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      n++;
      if (done_a === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n != 264) begin
      failures++; $display("FAIL run_latency got %0d (done seen=%b) required 264", n, got);
    end
    checks++;
    if (rd_bank_a !== 1'b0 || wr_bank_a !== 1'b1) begin
      failures++; $display("FAIL run_final_bank got rd=%b wr=%b required 0 1", rd_bank_a, wr_bank_a);
    end
    checks++;
    if (busy_a !== 1'b0 || en_a !== 2'b00 || round_a !== 5'd1) begin
      failures++; $display("FAIL run_done_state got busy=%b en=%b round=%0d required 0 00 1", busy_a, en_a, round_a);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (cyc_a !== 32'd264) begin
      failures++; $display("FAIL perf_count got %0d required 264", cyc_a);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin
      failures++; $display("FAIL done_hold got %b required 1", done_a);
    end
    start_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL done_release got done=%b busy=%b required 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_bank_routing();
    auto_mode = 1'b0; tb_done = 2'b00; tb_cnt = '0; wren_a = 2'b00; val_a = '0;
    @(negedge clk);
    start_a = 1'b1;
    wait_en_a(2'b01, "wait_stage0_run");
    tb_cnt[5:0] = 6'd5; val_a[24:0] = 25'h1ABCDEF; wren_a = 2'b01;
    #1;
    checks++;
    if (wr_en_a !== 1'b1 || wr_addr_a !== 6'd5 || rd_addr_a !== 6'd5) begin
      failures++; $display("FAIL s0_write_addr got en=%b wa=%0d ra=%0d required 1 5 5", wr_en_a, wr_addr_a, rd_addr_a);
    end
    checks++;
    if (wr_bank_a !== 1'b1 || rd_bank_a !== 1'b0 || wr_data_a !== 25'h1ABCDEF) begin
      failures++; $display("FAIL s0_write_bank got wb=%b rb=%b data=%h required 1 0 1abcdef", wr_bank_a, rd_bank_a, wr_data_a);
    end
    tb_cnt[11:6] = 6'd33; wren_a = 2'b10; tb_done = 2'b10;
    #1;
    checks++;
    if (wr_en_a !== 1'b0) begin
      failures++; $display("FAIL inactive_wr_dropped got %b required 0", wr_en_a);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (en_a !== 2'b01 || busy_a !== 1'b1 || wr_en_a !== 1'b0) begin
      failures++; $display("FAIL inactive_done_ignored got en=%b busy=%b wr_en=%b required 01 1 0", en_a, busy_a, wr_en_a);
    end
    tb_done = 2'b01; wren_a = 2'b00;
    @(negedge clk);
    tb_done = 2'b00;
    checks++;
    if (en_a !== 2'b00 || busy_a !== 1'b1) begin
      failures++; $display("FAIL swap_en_low got en=%b busy=%b required 00 1", en_a, busy_a);
    end
    wait_en_a(2'b10, "wait_stage1_run");
    tb_cnt[11:6] = 6'd9; val_a[49:25] = 25'h0123456; wren_a = 2'b10;
    #1;
    checks++;
    if (wr_en_a !== 1'b1 || wr_addr_a !== 6'd9 || wr_bank_a !== 1'b0 || rd_bank_a !== 1'b1 || wr_data_a !== 25'h0123456) begin
      failures++; $display("FAIL s1_write got en=%b wa=%0d wb=%b rb=%b data=%h required 1 9 0 1 0123456",
                           wr_en_a, wr_addr_a, wr_bank_a, rd_bank_a, wr_data_a);
    end
    tb_done = 2'b10; wren_a = 2'b00;
    @(negedge clk);
    tb_done = 2'b00;
    wait_en_a(2'b01, "wait_round1_stage0");
    checks++;
    if (round_a !== 5'd1 || rd_bank_a !== 1'b0) begin
      failures++; $display("FAIL round1_entry got round=%0d rb=%b required 1 0", round_a, rd_bank_a);
    end
  endtask

  task automatic test_reset_mid_run();
    wren_a = 2'b01;
    #1;
    checks++;
    if (wr_en_a !== 1'b1) begin
      failures++; $display("FAIL pre_reset_write got %b required 1", wr_en_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if ({done_a, busy_a, error_a, clr_a, en_a, wr_en_a, rd_bank_a} !== 9'd0 || round_a !== 5'd0) begin
      failures++; $display("FAIL async_reset got flags=%b round=%0d required 0 0",
                           {done_a, busy_a, error_a, clr_a, en_a, wr_en_a, rd_bank_a}, round_a);
    end
    start_a = 1'b0; wren_a = 2'b00;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (clr_a !== 2'b01 || round_a !== 5'd0 || busy_a !== 1'b1) begin
      failures++; $display("FAIL restart got clr=%b round=%0d busy=%b required 01 0 1", clr_a, round_a, busy_a);
    end
    @(negedge clk);
    rst_a = 1'b0; start_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_watchdog();
    int n;
    bit got;
    bit bad;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (en_b !== 2'b01) begin
      failures++; $display("FAIL wd_run_entry got %b required 01", en_b);
    end
    n = 0; got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      n++;
      if (error_b === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || n != 16) begin
      failures++; $display("FAIL wd_latency got %0d (error seen=%b) required 16", n, got);
    end
    checks++;
    if (en_b !== 2'b00 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      failures++; $display("FAIL wd_outputs got en=%b busy=%b done=%b required 00 0 0", en_b, busy_b, done_b);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (cyc_b !== 32'd17) begin
      failures++; $display("FAIL wd_perf_count got %0d required 17", cyc_b);
    end
`endif
    @(negedge clk);
    start_b = 1'b0;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (clr_b !== 2'b00 || en_b !== 2'b00 || busy_b !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || error_b !== 1'b1) begin
      failures++; $display("FAIL err_ignores_start got activity=%b error=%b required 0 1", bad, error_b);
    end
    start_b = 1'b0;
    rst_b = 1'b0;
    #1;
    checks++;
    if (error_b !== 1'b0) begin
      failures++; $display("FAIL err_cleared_by_reset got %b required 0", error_b);
    end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_run();
    test_bank_routing();
    test_reset_mid_run();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_step_sequencer.md
Name: encoder_step_sequencer

Overview:
- Top-level controller for the matrix encoder. Runs NUM_STAGES step engines in fixed order for NUM_ROUNDS rounds. Each engine is a rotate_en/donee/cnt_value/write_enable style block.
- Owns the shared ping-pong lane memory (2 banks x 64 x LANE_W). Routes the active engine's read address and write port, and flips banks after every stage.
- Includes a watchdog for hung engines.

Parameters:
- NUM_STAGES, 5, number of step engines (index 0 runs first).
- NUM_ROUNDS, 24, rounds per run.
- ADDR_W, 6, lane-line address width (64 lines).
- LANE_W, 25, bits per line.
- TIMEOUT_CYC, 1024, maximum RUN-state cycles per stage before error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request; a rising edge starts a run.
- done  out  1  high in DONE state.
- busy  out  1  high in CLEAR/RUN/SWAP.
- error  out  1  sticky watchdog flag.
- round  out  5  current round index.
- stage_clr  out  NUM_STAGES  one-hot one-cycle clear pulse to an engine.
- stage_en  out  NUM_STAGES  one-hot enable, held high during RUN.
- stage_done  in  NUM_STAGES  per-engine done.
- stage_cnt  in  NUM_STAGES*ADDR_W  per-engine line counters, packed, stage 0 in the LSBs.
- stage_wr_en  in  NUM_STAGES  per-engine write strobes.
- stage_wr_val  in  NUM_STAGES*LANE_W  per-engine write data.
- mem_rd_addr  out  ADDR_W  active engine's cnt.
- mem_rd_bank  out  1  bank being read.
- mem_wr_en  out  1  gated write strobe.
- mem_wr_addr  out  ADDR_W  active engine's cnt.
- mem_wr_bank  out  1  always the inverse of mem_rd_bank.
- mem_wr_data  out  LANE_W  active engine's write value.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; stage=0, round=0, rd_bank=0.
  - done, busy, error, stage_clr, stage_en and watchdog all 0.
  - Applies immediately, even mid-run. No memory write occurs while rst=0.
- start_q is a registered copy of start. A rising edge is start=1 and start_q=0.
- IDLE: on a rising edge, set stage=0, round=0, rd_bank=0 and go to CLEAR. Otherwise stay in IDLE.
- CLEAR (1 cycle): stage_clr[stage]=1, watchdog=0, then go to RUN.
- RUN:
  - stage_en[stage]=1 and watchdog increments each cycle.
  - If stage_done[stage]=1, go to SWAP.
  - Else if watchdog reaches TIMEOUT_CYC-1, go to ERR.
  - If done and timeout occur in the same cycle, done wins.
- SWAP (1 cycle): stage_en=0 and rd_bank toggles.
  - stage<NUM_STAGES-1: stage++, go to CLEAR.
  - Else if round<NUM_ROUNDS-1: stage=0, round++, go to CLEAR.
  - Else go to DONE.
- DONE: done=1 and rd_bank points at the result. When start=0, go to IDLE, clearing done.
- ERR: error=1 and all enables low. Held until reset; start is ignored.
- Start edges while busy are ignored.
- Only the active stage's stage_done, stage_wr_en and cnt are observed.
  - mem_wr_en = stage_wr_en[stage] and state==RUN. Writes outside RUN and writes from inactive engines are dropped.
- Address and data muxing is combinational from the registered stage index, so latency from the engine port to the memory port is 0 cycles.
- Overhead per stage is 2 cycles (CLEAR + SWAP).
- round saturates by construction; a width of 5 bits supports NUM_ROUNDS<=32.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds output cycle_count[31:0].
  - Cleared on a start edge; counts every non-IDLE, non-DONE, non-ERR cycle; saturates at 0xFFFFFFFF.
  - Holds its value in DONE/ERR/IDLE until the next start edge. Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package/header encoder_seq_pkg holds:
  - state encodings IDLE=0, CLEAR=1, RUN=2, SWAP=3, DONE=4, ERR=5;
  - the default ADDR_W=6 and LANE_W=25;
  - the LINES=64 constant.
- One sub-module is natural: stage_watchdog, a counter with clear and enable inputs and a terminal flag.

Test Plan:
- NUM_STAGES=2, NUM_ROUNDS=2, stub engines assert done 64 cycles after enable -> done rises exactly 4*(2+64) cycles after the start edge; final rd_bank=0 (four toggles).
- Per-stage bank routing: stage 0 writes line 5 with 0x1ABCDEF -> mem_wr_bank=1 and mem_wr_addr=5. Stage 1 writes from bank 1 and its data lands in bank 0.
- Inactive stage 1 asserts wr_en and done while stage 0 is running -> mem_wr_en stays 0 and the FSM stays in RUN.
- Stage never asserts done, TIMEOUT_CYC=16 -> error=1 16 cycles after entering RUN; stage_en=0; a later start edge produces no activity until rst pulse.
- rst=0 asserted mid-RUN in round 1 -> all outputs 0 within the same cycle. A fresh start then begins at round=0 with a stage_clr[0] pulse.
- SEQ_PERF_CNT_EN with the config from the first scenario -> cycle_count=264 in DONE; holding start=1 in DONE keeps done=1.
